shift_counter_param: RTL
========================

Name: shift_counter_param

Overview:
Parametrised twisted-ring (Johnson) / ring counter with run-time mode select, direction control, parallel load, illegal-state detection and self-correction, and a wrap pulse. It supersedes the fixed 4-bit Johnson counter in the counters library. It is used as a phase/sequence generator and decoded-state timer in datapath sequencing.

Parameters:
WIDTH, 4, number of state bits; legal range 2..32.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
en  input  1  step enable; counter advances one state per clk when 1.
mode  input  1  0 = Johnson (period 2*WIDTH), 1 = ring (period WIDTH).
dir  input  1  0 = shift toward MSB, 1 = shift toward LSB.
load  input  1  synchronous parallel load; has priority over en.
load_val  input  WIDTH  value captured on load.
q  output  WIDTH  counter state, registered.
tc  output  1  registered one-cycle pulse; high in the cycle q has just stepped into the seed state.
illegal  output  1  combinational; 1 when q is not a legal state for the current mode.

Behaviour:
- Reset (rst_n=0, asynchronous): q = 0, tc = 0. Reset is released synchronously to the design's clock; no output glitches are permitted after release.
- Seed state: Johnson = all zeros; ring = {0..0,1}, i.e. q[0]=1.
- Legal set, Johnson: at most one index i in 0..WIDTH-2 with q[i] != q[i+1]. This covers all 2*WIDTH states.
- Legal set, ring: exactly one bit set.
- illegal = not legal(q, mode). It updates immediately on a mode change. For example, q=0 in ring mode gives illegal=1.
- Next-state priority, per rising clk:
  1. load=1: q <= load_val and tc <= 0. load_val is accepted unchecked; illegal values are allowed.
  2. en=1 and illegal=1: q <= seed(mode) and tc <= 0. This is the correction step.
  3. en=1 and legal: q <= step(q) and tc <= (step(q) == seed).
  4. Otherwise: q holds and tc <= 0.
- step, Johnson, dir=0: {q[W-2:0], ~q[W-1]}.
- step, Johnson, dir=1: {~q[0], q[W-1:1]}.
- step, ring, dir=0: {q[W-2:0], q[W-1]}.
- step, ring, dir=1: {q[0], q[W-1:1]}.
- tc therefore fires once per full period in either direction. It never fires on load, correction or reset. With en held at 1, tc pulses every 2*WIDTH cycles (Johnson) or every WIDTH cycles (ring).
- A dir change takes effect on the next step with no extra latency. The reverse sequence is the exact reverse of the forward sequence.
- A mode change while q is legal in both modes (for example q=0001) continues stepping from q under the new mode with no correction.
- A mode change into an illegal state costs exactly one enabled cycle of correction to the seed. Counting resumes from the seed on the following enabled cycle.
- en=0: q and illegal are stable. tc returns to 0 one cycle after en drops.
- Reset asserted mid-sequence forces q=0 and tc=0 immediately, without waiting for clk.
- Latency: q reflects load/step one clk after the sampling edge. tc is aligned with the q update that enters the seed.

Test Plan:
- Johnson forward (WIDTH=4, mode=0, dir=0, en=1 from reset): q steps 0001,0011,0111,1111,1110,1100,1000,0000 -> tc=1 only with q=0000 (8th step); repeats with period 8; illegal stays 0.
- Johnson reverse: dir=1 from q=0000 -> q steps 1000,1100,1110,1111,0111,0011,0001,0000 -> tc on 0000. A dir toggle mid-sequence at q=0111 -> next q=1111.
- Ring mode: load 0001 then mode=1, en=1 -> q steps 0010,0100,1000,0001 -> tc with 0001, period 4. With dir=1 -> 1000,0100,0010,0001.
- Illegal correction: load 0101 in Johnson -> illegal=1. Next en cycle q=0000 with tc=0 and illegal=0; the following cycle q=0001. Switching to ring with q=0011 -> illegal=1 immediately, then q=0001.
- Priority and hold: load=1 with en=1 -> q=load_val, no step. en=0 for 5 cycles -> q unchanged, tc=0.
- Async reset: assert rst_n=0 between clock edges at q=1110 -> q=0000 and tc=0 without a clk edge. After release, with en=1, q=0001 on the first edge. Repeat with WIDTH=8 to confirm period 16 and tc spacing.

Source files
------------

// File: rtl/shift_counter_param.sv
// Parametrised Johnson/ring shift counter with run-time mode and direction,
// parallel load, illegal-state self-correction and a wrap pulse on seed entry.
module shift_counter_param #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             mode,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             illegal
);

  localparam logic [WIDTH-1:0] SEED_RING = WIDTH'(1);

  logic [WIDTH-2:0] edges;
  logic             legal_johnson;
  logic             legal_ring;
  logic [WIDTH-1:0] seed;
  logic [WIDTH-1:0] q_step;

  // A Johnson state has at most one boundary between adjacent differing bits.
  always_comb begin
    edges         = q[WIDTH-2:0] ^ q[WIDTH-1:1];
    legal_johnson = ($countones(edges) <= 1);
    legal_ring    = ($countones(q) == 1);
    illegal       = mode ? ~legal_ring : ~legal_johnson;
    seed          = mode ? SEED_RING : '0;
  end

  always_comb begin
    q_step = q;
    case ({mode, dir})
      2'b00:   q_step = {q[WIDTH-2:0], ~q[WIDTH-1]};
      2'b01:   q_step = {~q[0], q[WIDTH-1:1]};
      2'b10:   q_step = {q[WIDTH-2:0], q[WIDTH-1]};
      2'b11:   q_step = {q[0], q[WIDTH-1:1]};
      default: q_step = q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q  <= '0;
      tc <= 1'b0;
    end else if (load) begin
      q  <= load_val;
      tc <= 1'b0;
    end else if (en) begin
      if (illegal) begin
        q  <= seed;
        tc <= 1'b0;
      end else begin
        q  <= q_step;
        tc <= (q_step == seed);
      end
    end else begin
      tc <= 1'b0;
    end
  end

endmodule
